wash_stage_sequencer: RTL

WASH_STAGE_SEQUENCER -- requirements
Module: wash_stage_sequencer

---
 rtl/wash_pkg.sv | 17 +
 rtl/tick_divider.sv | 38 +++
 rtl/wash_stage_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/wash_pkg.sv
// Shared definitions for the wash stage sequencer: FSM state codes and
// default build parameters.
package wash_pkg;

  localparam int DEF_STAGES   = 3;
  localparam int DEF_TIME_W   = 8;
  localparam int DEF_TICK_DIV = 10;
  localparam int STATE_W      = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_DONE  = 3'd3
  } wash_state_e;

endpackage

// File: rtl/tick_divider.sv
// Free-running clock divider that produces one tick every TICK_DIV enabled
// cycles. The count holds while en is low, and clr forces it back to zero.
module tick_divider #(
  parameter int TICK_DIV = wash_pkg::DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Tick depends only on en and the count, never on clr, so the parent can
  // derive clr from tick without creating a combinational loop.
  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/wash_stage_sequencer.sv
// Multi-stage timed program sequencer (wash/rinse/spin). It snapshots the stage
// durations on start and steps through the stages on divided ticks, with
// pause/resume and abort.
module wash_stage_sequencer
  import wash_pkg::*;
#(
  parameter int STAGES   = DEF_STAGES,
  parameter int TIME_W   = DEF_TIME_W,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     abort,
  input  logic [STAGES*TIME_W-1:0] durations,
  output logic [STATE_W-1:0]       state,
  output logic [2:0]               stage,
  output logic [TIME_W-1:0]        remain,
  output logic [STAGES-1:0]        active,
  output logic                     done,
  output logic                     tick
);

  localparam logic [2:0]        LAST_STAGE = 3'(STAGES - 1);
  localparam logic [TIME_W-1:0] ONE        = TIME_W'(1);

  wash_state_e              state_q, state_d;
  logic [2:0]               stage_q, stage_d;
  logic [TIME_W-1:0]        remain_q, remain_d;
  logic [STAGES-1:0]        active_q, active_d;
  logic                     done_q, done_d;
  logic                     tick_q, tick_d;
  logic [STAGES*TIME_W-1:0] snap_q, snap_d;

  logic div_en, div_clr, div_tick;

  // A zero duration still occupies one full tick.
  function automatic logic [TIME_W-1:0] stage_len(
    input logic [STAGES*TIME_W-1:0] d,
    input logic [2:0]               idx
  );
    logic [TIME_W-1:0] v;
    v = d[idx*TIME_W +: TIME_W];
    return (v == '0) ? ONE : v;
  endfunction

  assign div_en = (state_q == S_RUN);

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .en  (div_en),
    .clr (div_clr),
    .tick(div_tick)
  );

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    remain_d = remain_q;
    snap_d   = snap_q;
    done_d   = 1'b0;
    tick_d   = 1'b0;
    div_clr  = 1'b0;

    if (abort) begin
      state_d  = S_IDLE;
      stage_d  = '0;
      remain_d = '0;
      div_clr  = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            snap_d   = durations;
            stage_d  = '0;
            remain_d = stage_len(durations, 3'd0);
            div_clr  = 1'b1;
            state_d  = S_RUN;
          end
        end
        S_RUN: begin
          if (div_tick) begin
            tick_d = 1'b1;
            if (remain_q > ONE) begin
              remain_d = remain_q - ONE;
            end else if (stage_q < LAST_STAGE) begin
              stage_d  = stage_q + 3'd1;
              remain_d = stage_len(snap_q, stage_q + 3'd1);
            end else begin
              state_d  = S_DONE;
              remain_d = '0;
              done_d   = 1'b1;
            end
          end
          // A pause that coincides with program completion is dropped.
          if (pause && (state_d == S_RUN)) state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (pause) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end

    active_d = (state_d == S_RUN) ? (STAGES'(1) << stage_d) : '0;
  end

  // NOTE: the duration snapshot is reset along with the control flops because it is cheap and keeps restarts deterministic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      stage_q  <= '0;
      remain_q <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
      tick_q   <= 1'b0;
      snap_q   <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      remain_q <= remain_d;
      active_q <= active_d;
      done_q   <= done_d;
      tick_q   <= tick_d;
      snap_q   <= snap_d;
    end
  end

  assign state  = state_q;
  assign stage  = stage_q;
  assign remain = remain_q;
  assign active = active_q;
  assign done   = done_q;
  assign tick   = tick_q;

  state_legal_a: assert property (@(posedge clk) disable iff (rst)
    state_q inside {S_IDLE, S_RUN, S_PAUSE, S_DONE});

  active_onehot_a: assert property (@(posedge clk) disable iff (rst)
    $onehot0(active_q));

  done_in_done_a: assert property (@(posedge clk) disable iff (rst)
    done_q |-> (state_q == S_DONE));

endmodule
